// File: rtl/spreader_oqpsk_tx.sv
// 802.15.4-style O-QPSK spreader: collects 4-bit symbols from a serial bit
// stream and emits 32 chips per symbol, alternating I/Q, one chip per CLK_DIV clocks.
module spreader_oqpsk_tx #(
   parameter int CLK_DIV = 25
) (
   input  logic clk,
   input  logic reset,
   input  logic bit_in,
   input  logic bit_valid,
   input  logic en,
   output logic tx_req,
   output logic chip_i,
   output logic chip_q,
   output logic chip_valid,
   output logic busy,
   output logic sym_ovf
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   // bit 31 holds c0, so chip n of the base sequence is BASE[31-n]
   localparam logic [31:0] BASE = 32'b11011001110000110101001000101110;

   typedef enum logic [1:0] {IDLE, LOAD, SPREAD} state_t;

   state_t          state, nxt;
   logic [3:0]      collect;
   logic [1:0]      bit_cnt;
   logic [3:0]      hold_sym;
   logic            hold_full;
   logic [3:0]      act_sym;
   logic [4:0]      chip_idx;
   logic [DW-1:0]   div_cnt;

   logic emit, last_chip, chain, load, sym_done;
   logic [3:0] new_sym;

   // Symbols 1..7 are rotations of symbol 0; 8..15 invert odd chips.
   function automatic logic chip_of(input logic [3:0] sym, input logic [4:0] idx);
      logic [4:0] n;
      n = idx - {sym[2:0], 2'b00};
      chip_of = BASE[5'd31 - n] ^ (sym[3] & idx[0]);
   endfunction

   assign sym_done = bit_valid && (bit_cnt == 2'd3);
   assign new_sym  = {bit_in, collect[3:1]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (en && hold_full) nxt = LOAD;
         LOAD:    nxt = SPREAD;
         SPREAD:  if (last_chip && !chain) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      emit      = (state == SPREAD) && (div_cnt == DW'(CLK_DIV - 1));
      last_chip = emit && (chip_idx == 5'd31);
      chain     = last_chip && hold_full && en;
      load      = (state == LOAD) || chain;
      busy      = (state != IDLE);
      tx_req    = en && !hold_full && !reset;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         collect    <= '0;
         bit_cnt    <= '0;
         hold_sym   <= '0;
         hold_full  <= 1'b0;
         sym_ovf    <= 1'b0;
         act_sym    <= '0;
         chip_idx   <= '0;
         div_cnt    <= '0;
         chip_i     <= 1'b0;
         chip_q     <= 1'b0;
         chip_valid <= 1'b0;
      end else begin
         chip_valid <= emit;
         if (bit_valid) begin
            collect <= new_sym;
            bit_cnt <= bit_cnt + 2'd1;
         end
         // a load in the same cycle frees the holding register for the new symbol
         if (sym_done && (!hold_full || load)) begin
            hold_sym  <= new_sym;
            hold_full <= 1'b1;
         end else if (load) begin
            hold_full <= 1'b0;
         end
         if (sym_done && hold_full && !load) sym_ovf <= 1'b1;

         if (state == SPREAD) begin
            if (emit) begin
               div_cnt  <= '0;
               chip_idx <= chip_idx + 5'd1;
               if (chip_idx[0]) chip_q <= chip_of(act_sym, chip_idx);
               else             chip_i <= chip_of(act_sym, chip_idx);
            end else begin
               div_cnt <= div_cnt + DW'(1);
            end
         end
         if (state == LOAD) begin
            chip_idx <= '0;
            div_cnt  <= '0;
         end
         if (load) act_sym <= hold_sym;
      end
   end

endmodule
